// File: rtl/output_display_pkg.sv
// Shared types and constants for the output-register display: FSM states,
// 7-segment patterns (bit 6 = g ... bit 0 = a) and the default scan divider.
package output_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_e;

   localparam int BCD_DIGITS      = 3;
   localparam int REFRESH_DIV_DEF = 1024;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_MINUS = 7'h40;

endpackage

// File: rtl/output_display_seg7_encode.sv
// Combinational BCD-digit to 7-segment encoder with a blanking override.
module seg7_encode
   import output_display_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   // Pattern lookup; codes above 9 render blank.
   always_comb begin
      seg_o = SEG_BLANK;
      if (blank_i) begin
         seg_o = SEG_BLANK;
      end else begin
         case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/output_display.sv
// Output-register display: captures CPU loads, converts them to sign + BCD with a
// serial double-dabble, and scans the digits onto a multiplexed 7-segment display.
module output_display
   import output_display_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
   input  logic              mclk,
   input  logic              i_rst_n,
   input  logic              mclk_en,
   input  logic              i_load_enable,
   input  logic [WIDTH-1:0]  i_load_data,
   input  logic              i_signed_mode,
   output logic [6:0]        o_seg,
   output logic [DIGITS-1:0] o_dig_sel,
   output logic              o_busy
);

   localparam int BCD_W  = 4 * BCD_DIGITS;
   localparam int SR_W   = BCD_W + WIDTH;
   localparam int CNT_W  = $clog2(WIDTH + 1);
   localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   state_e            state_q;
   logic              pend_q;
   logic [WIDTH-1:0]  slot_data_q;
   logic              slot_signed_q;
   logic [SR_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic              conv_neg_q;
   logic              busy_q;
   logic [BCD_W-1:0]  disp_bcd_q, disp_bcd_d;
   logic              disp_neg_q, disp_neg_d;
   logic [SCAN_W-1:0] scan_cnt_q;
   logic              scan_wrap_s;
   logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
   logic [6:0]        seg_q, seg_d, enc_seg_s;
   logic [3:0]        sel_idx_s, cur_bcd_s;
   logic              cur_blank_s, cur_sign_s;
   logic              load_acc_s, slot_neg_s;
   logic [WIDTH-1:0]  mag_s;
   logic              hund_zero_s, tens_zero_s;

   assign load_acc_s = mclk_en & i_load_enable;
   assign slot_neg_s = slot_signed_q & slot_data_q[WIDTH-1];
   // Unsigned reinterpretation of the negation makes the most negative value its own magnitude.
   assign mag_s      = slot_neg_s ? (~slot_data_q + WIDTH'(1)) : slot_data_q;

   // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
   always_comb begin
      shift_d = shift_q;
      for (int k = 0; k < BCD_DIGITS; k++) begin
         if (shift_d[WIDTH + 4*k +: 4] >= 4'd5) begin
            shift_d[WIDTH + 4*k +: 4] = shift_d[WIDTH + 4*k +: 4] + 4'd3;
         end else begin
            shift_d[WIDTH + 4*k +: 4] = shift_d[WIDTH + 4*k +: 4];
         end
      end
      shift_d = {shift_d[SR_W-2:0], 1'b0};
   end

   assign disp_bcd_d = (state_q == ST_COMMIT) ? shift_q[SR_W-1:WIDTH] : disp_bcd_q;
   assign disp_neg_d = (state_q == ST_COMMIT) ? conv_neg_q : disp_neg_q;

   // Pending slot, conversion FSM and display registers.
   always_ff @(posedge mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         pend_q        <= 1'b0;
         slot_data_q   <= '0;
         slot_signed_q <= 1'b0;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         conv_neg_q    <= 1'b0;
         busy_q        <= 1'b0;
         disp_bcd_q    <= '0;
         disp_neg_q    <= 1'b0;
      end else begin
         if (load_acc_s) begin
            pend_q        <= 1'b1;
            slot_data_q   <= i_load_data;
            slot_signed_q <= i_signed_mode;
         end else if ((state_q == ST_IDLE) && pend_q) begin
            pend_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (pend_q) begin
                  state_q    <= ST_CONVERT;
                  shift_q    <= {{BCD_W{1'b0}}, mag_s};
                  conv_neg_q <= slot_neg_s;
                  bit_cnt_q  <= '0;
                  busy_q     <= 1'b1;
               end
            end
            ST_CONVERT: begin
               shift_q   <= shift_d;
               bit_cnt_q <= bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
         disp_bcd_q <= disp_bcd_d;
         disp_neg_q <= disp_neg_d;
      end
   end

   assign scan_wrap_s = (scan_cnt_q == SCAN_W'(REFRESH_DIV - 1));
   assign dig_sel_d   = scan_wrap_s ? {dig_sel_q[DIGITS-2:0], dig_sel_q[DIGITS-1]} : dig_sel_q;
   assign hund_zero_s = (disp_bcd_d[11:8] == 4'd0);
   assign tens_zero_s = (disp_bcd_d[7:4] == 4'd0);

   // Pick the digit for the next selected position, from next-state values so o_seg tracks o_dig_sel.
   always_comb begin
      sel_idx_s   = 4'd0;
      cur_bcd_s   = 4'd0;
      cur_blank_s = 1'b1;
      cur_sign_s  = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_sel_d[i]) begin
            sel_idx_s = 4'(i);
         end else begin
            sel_idx_s = sel_idx_s;
         end
      end
      if (sel_idx_s == 4'(DIGITS - 1)) begin
         cur_sign_s = 1'b1;
      end else begin
         case (sel_idx_s)
            4'd0: begin
               cur_bcd_s   = disp_bcd_d[3:0];
               cur_blank_s = 1'b0;
            end
            4'd1: begin
               cur_bcd_s   = disp_bcd_d[7:4];
               cur_blank_s = hund_zero_s & tens_zero_s;
            end
            4'd2: begin
               cur_bcd_s   = disp_bcd_d[11:8];
               cur_blank_s = hund_zero_s;
            end
            default: begin
               cur_bcd_s   = 4'd0;
               cur_blank_s = 1'b1;
            end
         endcase
      end
   end

   seg7_encode u_seg7_encode (
      .bcd_i   (cur_bcd_s),
      .blank_i (cur_blank_s),
      .seg_o   (enc_seg_s)
   );

   assign seg_d = cur_sign_s ? (disp_neg_d ? SEG_MINUS : SEG_BLANK) : enc_seg_s;

   // Digit scan counter and registered display outputs.
   always_ff @(posedge mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scan_cnt_q <= '0;
         dig_sel_q  <= {{(DIGITS-1){1'b0}}, 1'b1};
         seg_q      <= SEG_0;
      end else begin
         scan_cnt_q <= scan_wrap_s ? '0 : scan_cnt_q + SCAN_W'(1);
         dig_sel_q  <= dig_sel_d;
         seg_q      <= seg_d;
      end
   end

   assign o_seg     = seg_q;
   assign o_dig_sel = dig_sel_q;
   assign o_busy    = busy_q;

endmodule

// File: doc/output_display.md
OUTPUT_DISPLAY -- requirements
Module: output_display

Interface — parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the width of the captured output-register value.
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the number of displayed digits: hundreds, tens and units, plus one sign digit on the left.
REQ-003 The block SHALL have parameter REFRESH_DIV, default 1024, giving the number of mclk cycles each digit stays selected.

Interface — ports
REQ-004 mclk  input  1  single system clock; all state changes on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 mclk_en  input  1  CPU step enable; qualifies loads only.
REQ-007 i_load_enable  input  1  output-register load strobe; a load is accepted when mclk_en & i_load_enable.
REQ-008 i_load_data  input  WIDTH  value being written to the output register.
REQ-009 i_signed_mode  input  1  1 = treat the value as two's complement; 0 = unsigned.
REQ-010 o_seg  output  7  segments a..g, active-high.
REQ-011 o_dig_sel  output  DIGITS  one-hot digit enable; bit 0 = units.
REQ-012 o_busy  output  1  high while a BCD conversion is in progress.

Function
REQ-013 An accepted load SHALL capture i_load_data and i_signed_mode into a pending slot and set a pending flag.
REQ-014 The FSM SHALL have three states: IDLE, CONVERT and COMMIT.
REQ-015 IDLE -> CONVERT SHALL occur when the pending flag is set; on that transition the FSM consumes the flag and copies the slot into the shift register.
REQ-016 On entry to CONVERT, negative signed values SHALL be negated first; the magnitude of -128 SHALL be 128.
REQ-017 CONVERT SHALL run shift-and-add-3 (double-dabble) for exactly WIDTH cycles, unconditioned on mclk_en, then go to COMMIT.
REQ-018 COMMIT SHALL last one cycle, copy the BCD digits and the sign into the display registers, and return to IDLE.
REQ-019 Load-to-display latency SHALL be WIDTH+2 mclk cycles, counted from the accepting edge to the display-register update.
REQ-020 A load during CONVERT or COMMIT SHALL overwrite the pending slot without disturbing the running conversion; only the last such load is displayed afterwards.
REQ-021 A load in the same cycle that IDLE consumes the pending flag SHALL leave the flag set with the new value.
REQ-022 o_busy SHALL be high in CONVERT and COMMIT and low in IDLE.
REQ-023 The scan counter SHALL count 0..REFRESH_DIV-1 and wrap.
REQ-024 At each wrap of the scan counter, o_dig_sel SHALL rotate left by one position, from bit DIGITS-1 back to bit 0.
REQ-025 Leading-zero blanking SHALL apply: hundreds blank when zero; tens blank when hundreds and tens are both zero; units always shown.
REQ-026 The sign digit SHALL show segment g only, when the value is negative in signed mode, and be blank otherwise.
REQ-027 o_seg and o_dig_sel SHALL be registered outputs.

Reset
REQ-028 On i_rst_n low, asynchronously: FSM to IDLE; pending flag 0; display value 0 with sign off; scan counter 0; o_dig_sel = 0001; o_seg = 7'b0111111 ("0"); o_busy 0.
REQ-029 Reset asserted during CONVERT SHALL discard both the conversion and the pending load.

Structure
REQ-030 A shared package SHALL hold: the FSM state enum; the 7-segment constants for 0-9, blank and minus; the default REFRESH_DIV.
REQ-031 Sub-module seg7_encode SHALL be the single natural sub-module: combinational, 4-bit BCD plus blank flag in, 7 segments out.

Verification
REQ-032 Reset release, no load -> units digit shows 7'b0111111 and other digits blank; o_dig_sel cycles 0001, 0010, 0100, 1000, each held REFRESH_DIV cycles.
REQ-033 Unsigned load 8'hFF -> o_busy high for 9 cycles (WIDTH+1: CONVERT plus COMMIT); display reads "255", sign blank, after 10 cycles (WIDTH+2).
REQ-034 Signed load 8'h80 -> display reads "-128"; signed load 8'hF6 -> display reads "-10" with hundreds blank.
REQ-035 Load 8'd7, then load 8'd42 during CONVERT -> "7" is displayed, then "42" after a second conversion; no third conversion occurs.
REQ-036 Load with mclk_en low -> ignored and o_busy stays low; reset pulse mid-CONVERT -> reset state per REQ-028 and no later display update.
